hdmi_window_timing: RTL and testbench
=====================================

# hdmi_window_timing

Parametrised successor to the fixed 640x480 HDMI controller: generates programmable-resolution video timing and fetches a rectangular image window from a synchronous pixel memory. The image origin is runtime-movable, and sync polarities are configurable. Sits between the frame/image ROM (driven via `PX_ADDR` and `PX_RD`) and the HDMI transmitter (driven via `DE`, `HSYNC`, `VSYNC` and RGB). All video outputs are registered and mutually aligned.

## Interface
- `H_ACTIVE`, 640, active pixels per line (multiple of 8)
- `H_FP`, 16, horizontal front porch, in pixels
- `H_SYNC`, 96, horizontal sync width, in pixels
- `H_BP`, 48, horizontal back porch, in pixels
- `V_ACTIVE`, 480, active lines
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vertical sync width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `HS_POL`, 0, asserted level of `HSYNC` (0 = active-low)
- `VS_POL`, 0, asserted level of `VSYNC`
- `IMG_W`, 185, image width in pixels
- `IMG_H`, 185, image height in pixels
- `CNT_W`, 12, width of the x/y counters and of `IMG_X`/`IMG_Y`
- `ADDR_W`, 17, pixel address width (`IMG_W*IMG_H` ≤ 2^`ADDR_W`)

Ports:
- `CLK_PX` in 1: pixel clock
- `RST_n` in 1: asynchronous, active-low reset
- `IMG_X` in `CNT_W`: window left column, in active coordinates
- `IMG_Y` in `CNT_W`: window top line, in active coordinates
- `BG` in 24: background colour {R,G,B}, for active pixels outside the window
- `PX` in 24: memory read data, valid one cycle after `PX_ADDR`/`PX_RD`
- `PX_ADDR` out `ADDR_W`: registered read address
- `PX_RD` out 1: registered read strobe
- `HDMI_CLK` out 1: equals `CLK_PX`
- `DE` out 1: data enable
- `HSYNC` out 1: horizontal sync
- `VSYNC` out 1: vertical sync
- `RED` out 8: red channel
- `GREEN` out 8: green channel
- `BLUE` out 8: blue channel
- `FRAME_START` out 1: one-cycle pulse, coincident with output pixel (0,0)

## Operation
**Counters**
- x runs 0..`H_TOTAL`-1 and wraps to 0; `H_TOTAL` = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP`.
- y increments when x wraps, runs 0..`V_TOTAL`-1, and wraps to 0.
- The active region is x<`H_ACTIVE` and y<`V_ACTIVE`; x=0,y=0 is the first active pixel.

**Sync**
- `HSYNC` is asserted for `H_ACTIVE`+`H_FP` ≤ x < `H_ACTIVE`+`H_FP`+`H_SYNC`.
- `VSYNC` is asserted for whole lines `V_ACTIVE`+`V_FP` ≤ y < `V_ACTIVE`+`V_FP`+`V_SYNC`.
- Both are deasserted (driven to the complement of `*_POL`) otherwise.

**Window origin**
- `IMG_X`/`IMG_Y` are sampled into shadow registers when x=0,y=0.
- Changes made mid-frame take effect at the next frame.

**Window and addressing**
- The window is sx ≤ x < sx+`IMG_W` and sy ≤ y < sy+`IMG_H`, where sx/sy are the shadow values.
- The window is clipped to the active region; clipped pixels issue no read.
- Address = row_base + (x − sx).
- row_base is 0 at frame start and increases by `IMG_W` after each line with y inside [sy, sy+`IMG_H`).
- Column-clipped pixels therefore do not shift the addresses of later rows.
- `PX_RD`=1 exactly for pixels inside the clipped window.

**Colour**
- Window pixel: RGB = `PX`.
- Active pixel outside the window: RGB = `BG`.
- Non-active pixel: RGB = 0 and `DE`=0.

## Timing
- Counter state (x,y) at cycle k produces `PX_ADDR`/`PX_RD` in cycle k+1.
- The memory returns `PX` in cycle k+2.
- `DE`, `HSYNC`, `VSYNC`, RGB and `FRAME_START` are valid in cycle k+3, so all video outputs share a fixed 3-cycle latency.
- Reset values:
  - x=y=0, shadow registers 0, row_base 0
  - `PX_ADDR`=0, `PX_RD`=0, `DE`=0, RGB=0, `FRAME_START`=0
  - `HSYNC`=~`HS_POL`, `VSYNC`=~`VS_POL`
- Reset asserted mid-frame: all of the above apply immediately and the pipeline is flushed.
- After release, the first `FRAME_START` occurs in the 4th cycle, i.e. 3 cycles after the first rising edge.
- Window extending past `H_ACTIVE` or `V_ACTIVE` (e.g. sx ≥ `H_ACTIVE`): no reads are issued for the clipped part; the rest of the frame is normal.
- The last frame line wraps to the first with no gap cycle.

## Configuration
- `HDMI_TEST_PATTERN_EN` defined:
  - Adds input `TP_EN` (1 bit).
  - When `TP_EN`=1, the active area shows 8 vertical bars, each `H_ACTIVE`/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black (channels FF/00).
  - `PX_RD` is held at 0 while `TP_EN`=1.
  - `TP_EN` is sampled with the shadow registers, at frame start.
- `HDMI_TEST_PATTERN_EN` undefined: the port and the logic are absent, and behaviour is as described above.

## Test plan
1. **Reset values:** assert `RST_n`=0 → all outputs hold their reset values; release → `FRAME_START` pulses in cycle 4 with `DE`=1.
2. **Default line/frame timing:**
   - `DE` high for 640 cycles, then low for 160 cycles.
   - `HSYNC`=0 for 96 cycles, starting 656 cycles after the `DE` rise.
   - `VSYNC`=0 for 1600 cycles, starting at line 490.
   - Frame period = 420000 cycles.
3. **Small window** (`IMG_W`=4, `IMG_H`=2, `IMG_X`=10, `IMG_Y`=5; memory model returns `PX`=address):
   - `PX_ADDR` 0..3 on line 5 (x=10..13), 4..7 on line 6, with `PX_RD` high only for those pixels.
   - RGB shows 0..7 at those positions three cycles later; all other active pixels show `BG`.
4. **Clipping:** `IMG_X`=638, `IMG_W`=4 → line 5 reads addresses 0,1 and line 6 reads 4,5; no reads at x ≥ 640.
5. **Shadowing and reset mid-frame:**
   - Change `IMG_X` at line 100 → the current frame still uses the old origin; the next frame uses the new one.
   - Pulse `RST_n` low mid-line → outputs return to reset values at once and timing restarts at (0,0).
6. **Test pattern** (with `HDMI_TEST_PATTERN_EN`, `TP_EN`=1):
   - x=0 → FFFFFF; x=80 → FFFF00; x=560 → 000000.
   - `PX_RD` stays 0 for the entire frame.

Source files
------------

// File: rtl/hdmi_window_timing.sv
// Programmable video timing with a movable image window fetched from synchronous pixel memory.
// Optional colour-bar generator enabled by defining HDMI_TEST_PATTERN_EN.
module hdmi_window_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned IMG_W    = 185,
  parameter int unsigned IMG_H    = 185,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              CLK_PX,
  input  logic              RST_n,
`ifdef HDMI_TEST_PATTERN_EN
  input  logic              TP_EN,
`endif
  input  logic [CNT_W-1:0]  IMG_X,
  input  logic [CNT_W-1:0]  IMG_Y,
  input  logic [23:0]       BG,
  input  logic [23:0]       PX,
  output logic [ADDR_W-1:0] PX_ADDR,
  output logic              PX_RD,
  output logic              HDMI_CLK,
  output logic              DE,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic [7:0]        RED,
  output logic [7:0]        GREEN,
  output logic [7:0]        BLUE,
  output logic              FRAME_START
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0]  H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_SS_C   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0]  H_SE_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0]  V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  V_LAST_C = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  V_SS_C   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0]  V_SE_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W:0]    IMG_W_X  = (CNT_W+1)'(IMG_W);
  localparam logic [CNT_W:0]    IMG_H_Y  = (CNT_W+1)'(IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);

  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d, sx_q, sy_q, cur_sx, cur_sy;
  logic [CNT_W:0]    x_e, y_e, sx_e, sy_e;
  logic [ADDR_W-1:0] row_base_q, row_base_d, rd_addr;
  logic              frame_start, active, col_in, row_in, win, hs0, vs0;

  // Pipeline stages 1 and 2 carry the timing flags alongside the memory access.
  logic de1, hs1, vs1, fs1;
  logic de2, hs2, vs2, fs2, win2;
  logic [23:0] rgb_d;

`ifdef HDMI_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(H_ACTIVE / 8);
  logic       tp_q, cur_tp, tp0, tp1, tp2;
  logic [2:0] bar0, bar1, bar2;

  always_comb begin
    cur_tp = frame_start ? TP_EN : tp_q;
    tp0    = cur_tp && active;
    bar0   = 3'(x_q / BAR_W_C);
  end
`endif

  assign HDMI_CLK = CLK_PX;

  always_comb begin
    frame_start = (x_q == '0) && (y_q == '0);
    // The frame starting now already uses the freshly sampled origin.
    cur_sx = frame_start ? IMG_X : sx_q;
    cur_sy = frame_start ? IMG_Y : sy_q;
    x_e    = {1'b0, x_q};
    y_e    = {1'b0, y_q};
    sx_e   = {1'b0, cur_sx};
    sy_e   = {1'b0, cur_sy};
    active = (x_q < H_ACT_C) && (y_q < V_ACT_C);
    col_in = (x_e >= sx_e) && (x_e < sx_e + IMG_W_X);
    row_in = (y_e >= sy_e) && (y_e < sy_e + IMG_H_Y);
    win    = active && col_in && row_in;
`ifdef HDMI_TEST_PATTERN_EN
    if (cur_tp) win = 1'b0;
`endif
    rd_addr = row_base_q + ADDR_W'(x_q - cur_sx);
    hs0 = ((x_q >= H_SS_C) && (x_q < H_SE_C)) ? HS_POL : ~HS_POL;
    vs0 = ((y_q >= V_SS_C) && (y_q < V_SE_C)) ? VS_POL : ~VS_POL;
  end

  always_comb begin
    x_d        = x_q + 1'b1;
    y_d        = y_q;
    row_base_d = row_base_q;
    if (x_q == H_LAST_C) begin
      x_d = '0;
      if (y_q == V_LAST_C) begin
        y_d        = '0;
        row_base_d = '0;
      end else begin
        y_d = y_q + 1'b1;
        // Advance per window row regardless of column clipping.
        if (row_in) row_base_d = row_base_q + IMG_W_A;
      end
    end
  end

  always_comb begin
    rgb_d = '0;
    if (de2) begin
      rgb_d = win2 ? PX : BG;
`ifdef HDMI_TEST_PATTERN_EN
      if (tp2) rgb_d = {{8{~bar2[1]}}, {8{~bar2[2]}}, {8{~bar2[0]}}};
`endif
    end
  end

  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      x_q         <= '0;
      y_q         <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      row_base_q  <= '0;
      PX_ADDR     <= '0;
      PX_RD       <= 1'b0;
      de1         <= 1'b0;
      hs1         <= ~HS_POL;
      vs1         <= ~VS_POL;
      fs1         <= 1'b0;
      de2         <= 1'b0;
      hs2         <= ~HS_POL;
      vs2         <= ~VS_POL;
      fs2         <= 1'b0;
      win2        <= 1'b0;
      DE          <= 1'b0;
      HSYNC       <= ~HS_POL;
      VSYNC       <= ~VS_POL;
      FRAME_START <= 1'b0;
      RED         <= '0;
      GREEN       <= '0;
      BLUE        <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      if (frame_start) begin
        sx_q <= IMG_X;
        sy_q <= IMG_Y;
      end
      PX_RD <= win;
      if (win) PX_ADDR <= rd_addr;
      de1   <= active;
      hs1   <= hs0;
      vs1   <= vs0;
      fs1   <= frame_start;
      de2   <= de1;
      hs2   <= hs1;
      vs2   <= vs1;
      fs2   <= fs1;
      win2  <= PX_RD;
      DE          <= de2;
      HSYNC       <= hs2;
      VSYNC       <= vs2;
      FRAME_START <= fs2;
      {RED, GREEN, BLUE} <= rgb_d;
    end
  end

`ifdef HDMI_TEST_PATTERN_EN
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      tp_q <= 1'b0;
      tp1  <= 1'b0;
      tp2  <= 1'b0;
      bar1 <= '0;
      bar2 <= '0;
    end else begin
      if (frame_start) tp_q <= TP_EN;
      tp1  <= tp0;
      tp2  <= tp1;
      bar1 <= bar0;
      bar2 <= bar1;
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_window_timing.sv
// Bench for hdmi_window_timing on a reduced 24x12 raster: arithmetic reference model plus literal checks.
module tb_hdmi_window_timing;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3, HT = HA + HFP + HSW + HBP;
  localparam int VA = 8, VFP = 1, VSW = 2, VBP = 1, VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int IW = 4, IH = 2;
  localparam bit HPOL = 1'b0, VPOL = 1'b1;
  localparam logic [23:0] BGC = 24'h123456;

  logic        CLK_PX = 1'b0;
  logic        RST_n;
  logic        TP_EN;
  logic [7:0]  IMG_X, IMG_Y;
  logic [23:0] BG, PX;
  logic [7:0]  PX_ADDR;
  logic        PX_RD, HDMI_CLK, DE, HSYNC, VSYNC, FRAME_START;
  logic [7:0]  RED, GREEN, BLUE;

  always #5 CLK_PX = ~CLK_PX;

  hdmi_window_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HPOL), .VS_POL(VPOL), .IMG_W(IW), .IMG_H(IH), .CNT_W(8), .ADDR_W(8)
  ) dut (
    .CLK_PX(CLK_PX), .RST_n(RST_n),
`ifdef HDMI_TEST_PATTERN_EN
    .TP_EN(TP_EN),
`endif
    .IMG_X(IMG_X), .IMG_Y(IMG_Y), .BG(BG), .PX(PX),
    .PX_ADDR(PX_ADDR), .PX_RD(PX_RD), .HDMI_CLK(HDMI_CLK), .DE(DE),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .FRAME_START(FRAME_START)
  );

  // Synchronous memory: data is a tagged copy of the address.
  always @(posedge CLK_PX) PX <= 24'h5A0000 | {16'h0, PX_ADDR};

  // Rising edges since the last reset release.
  int e;
  always @(posedge CLK_PX or negedge RST_n)
    if (!RST_n) e <= 0;
    else e <= e + 1;

  int org_x[8], org_y[8];
  bit org_tp[8];
  int n_tests = 0, n_fail = 0;
  int seg = -1;
  bit was_rst = 1'b1;
  int de_c, hs_c, vs_c, rd_c, asum;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t e=%0d: got %0h, want %0h", name, $time, e, act, exp);
    end
  endtask

  // Expected behaviour of pixel number p (counted from reset release).
  task automatic model(input int p, output bit rd, output int addr, output bit de,
                       output bit hs, output bit vs, output bit fs, output logic [23:0] rgb);
    int f, q, x, y, sx, sy;
    bit tp, act;
    f = (p / FRAME) % 8;
    q = p % FRAME;
    x = q % HT;
    y = q / HT;
    sx = org_x[f];
    sy = org_y[f];
    tp = org_tp[f];
    act  = (x < HA) && (y < VA);
    rd   = act && !tp && x >= sx && x < sx + IW && y >= sy && y < sy + IH;
    addr = (y - sy) * IW + (x - sx);
    de   = act;
    hs   = (x >= HA + HFP && x < HA + HFP + HSW) ? HPOL : !HPOL;
    vs   = (y >= VA + VFP && y < VA + VFP + VSW) ? VPOL : !VPOL;
    fs   = (q == 0);
    if (!act) rgb = 24'h0;
    else if (tp) rgb = bars[x / (HA / 8)];
    else if (rd) rgb = 24'h5A0000 | 24'(addr);
    else rgb = BGC;
  endtask

  // Hand-counted reads per completed frame: {count, address sum}; -1 = not checked.
  function automatic int exp_rd(input int s, input int f, input bit sum);
    case (s * 10 + f)
      0:  return sum ? 28 : 8;
      1:  return sum ? 10 : 4;
      2:  return sum ? 6 : 4;
      10: return sum ? 28 : 8;
      11: return 0;
      default: return -1;
    endcase
  endfunction

  initial begin : monitor
    bit rd, de, hs, vs, fs;
    int addr, q;
    logic [23:0] rgb;
    forever begin
      @(negedge CLK_PX);
      chk("hdmi_clk", 64'(HDMI_CLK), 64'd0);
      if (!RST_n) begin
        was_rst = 1'b1;
        chk("reset_vals", {PX_RD, PX_ADDR, DE, HSYNC, VSYNC, FRAME_START, RED, GREEN, BLUE},
            {1'b0, 8'h00, 1'b0, ~HPOL, ~VPOL, 1'b0, 24'h0});
      end else begin
        if (was_rst) begin
          seg++;
          was_rst = 1'b0;
        end
        if (e % FRAME == 0) begin
          org_x[(e / FRAME) % 8] = int'(IMG_X);
          org_y[(e / FRAME) % 8] = int'(IMG_Y);
`ifdef HDMI_TEST_PATTERN_EN
          org_tp[(e / FRAME) % 8] = TP_EN;
`else
          org_tp[(e / FRAME) % 8] = 1'b0;
`endif
        end
        if (e >= 1) begin
          model(e - 1, rd, addr, de, hs, vs, fs, rgb);
          q = (e - 1) % FRAME;
          if (q == 0) begin
            rd_c = 0;
            asum = 0;
          end
          chk("px_rd", 64'(PX_RD), 64'(rd));
          if (rd) chk("px_addr", 64'(PX_ADDR), 64'(addr));
          if (PX_RD) begin
            rd_c++;
            asum += int'(PX_ADDR);
          end
          if (q == FRAME - 1 && exp_rd(seg, (e - 1) / FRAME, 1'b0) >= 0) begin
            chk("frame_reads", 64'(rd_c), 64'(exp_rd(seg, (e - 1) / FRAME, 1'b0)));
            chk("frame_addr_sum", 64'(asum), 64'(exp_rd(seg, (e - 1) / FRAME, 1'b1)));
          end
        end else begin
          chk("rd_idle", {PX_RD, PX_ADDR}, 64'd0);
        end
        if (e >= 3) begin
          model(e - 3, rd, addr, de, hs, vs, fs, rgb);
          q = (e - 3) % FRAME;
          chk("de", 64'(DE), 64'(de));
          chk("hsync", 64'(HSYNC), 64'(hs));
          chk("vsync", 64'(VSYNC), 64'(vs));
          chk("frame_start", 64'(FRAME_START), 64'(fs));
          chk("rgb", {RED, GREEN, BLUE}, 64'(rgb));
          if (q == 0) begin
            de_c = 0;
            hs_c = 0;
            vs_c = 0;
          end
          de_c += int'(DE);
          hs_c += int'(HSYNC == HPOL);
          vs_c += int'(VSYNC == VPOL);
          if (q == FRAME - 1) begin
            chk("de_cycles_per_frame", 64'(de_c), 64'd128);
            chk("hsync_cycles_per_frame", 64'(hs_c), 64'd36);
            chk("vsync_cycles_per_frame", 64'(vs_c), 64'd48);
          end
        end else begin
          chk("video_idle", {DE, HSYNC, VSYNC, FRAME_START, RED, GREEN, BLUE},
              {1'b0, ~HPOL, ~VPOL, 1'b0, 24'h0});
        end
        if (e == 3) chk("first_fs_de", {FRAME_START, DE}, 64'b11);
        if (seg == 0 && e == 3) chk("bg_at_origin", {RED, GREEN, BLUE}, 64'h123456);
        if (seg == 0 && e == 3 * HT + 6 + 3) chk("win_px1", {RED, GREEN, BLUE}, 64'h5A0001);
        if (seg == 1 && e == 3) chk("win_px0", {RED, GREEN, BLUE}, 64'h5A0000);
`ifdef HDMI_TEST_PATTERN_EN
        if (seg == 1 && e == FRAME + 3) chk("tp_x0", {RED, GREEN, BLUE}, 64'hFFFFFF);
        if (seg == 1 && e == FRAME + 5) chk("tp_x2", {RED, GREEN, BLUE}, 64'hFFFF00);
        if (seg == 1 && e == FRAME + 17) chk("tp_x14", {RED, GREEN, BLUE}, 64'h000000);
`endif
      end
    end
  end

  task automatic wait_e(input int target);
    int g;
    g = 0;
    while (e != target) begin
      @(posedge CLK_PX);
      #1;
      g++;
      if (g > 5000) begin
        $display("FAIL wait_e timeout: e=%0d, want %0d", e, target);
        $fatal(1, "wait_e timeout");
      end
    end
  endtask

  initial begin
    RST_n = 1'b0;
    IMG_X = 8'd5;
    IMG_Y = 8'd3;
    BG    = BGC;
    TP_EN = 1'b0;
    repeat (4) @(posedge CLK_PX);
    #1 RST_n = 1'b1;
    wait_e(5 * HT + 7);
    IMG_X = 8'd14;
    wait_e(FRAME + 5 * HT);
    IMG_X = 8'd2;
    IMG_Y = 8'd7;
    wait_e(2 * FRAME + 100);
    IMG_X = 8'd20;
    IMG_Y = 8'd0;
    wait_e(3 * FRAME + 4 * HT + 10);
    RST_n = 1'b0;
    IMG_X = 8'd0;
    IMG_Y = 8'd0;
    repeat (2) @(posedge CLK_PX);
    #1 RST_n = 1'b1;
`ifdef HDMI_TEST_PATTERN_EN
    wait_e(50);
    TP_EN = 1'b1;
    wait_e(2 * FRAME + 10);
`else
    wait_e(FRAME + 50);
`endif
    @(posedge CLK_PX);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
